bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the per-digit seven-segment decoders on the piano board. It converts a note's frequency or count value into packed BCD nibbles, and each 4-bit digit feeds one decoder instance. Start/busy/done handshake; the result is held stable between conversions so the displays never flicker mid-conversion.

---
 rtl/piano_disp_pkg.sv | 27 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/piano_disp_pkg.sv
// Shared display-path definitions for the piano board.
// Used by the BCD converter and the seven-segment decoders.
package piano_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  localparam logic [3:0] BCD_NINE = 4'h9;

  // ceil(w * log10(2)): decimal digits needed for 2^w-1
  function automatic int dec_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 when digit >= 5.
// Purely combinational, one instance per scratch digit.
module bcd_digit_adj
  import piano_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] dig_i,
  output logic [BCD_DIGIT_W-1:0] dig_o
);

  assign dig_o = (dig_i >= BCD_DIGIT_W'(ADD3_THRESH))
               ? dig_i + BCD_DIGIT_W'(3)
               : dig_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock.
// Result and overflow are held between conversions.
module bin_to_bcd_seq
  import piano_disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int SD_RAW = dec_digits(BIN_W);
  localparam int SD     = (SD_RAW > DIGITS) ? SD_RAW : DIGITS;
  localparam int SC_W   = SD * BCD_DIGIT_W;
  localparam int SR_W   = SC_W + BIN_W;
  localparam int OUT_W  = DIGITS * BCD_DIGIT_W;
  localparam int CW     = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  if (BIN_W < 1 || DIGITS < 1) begin : g_bad_param
    $error("bin_to_bcd_seq: BIN_W and DIGITS must be >= 1");
  end

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [OUT_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shl;

  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];

  for (genvar g = 0; g < SD; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (sr_q[BIN_W+g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dig_o (sr_adj[BIN_W+g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign sr_shl = sr_adj << 1;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = {{SC_W{1'b0}}, bin_in};
          cnt_d      = CW'(BIN_W);
          ovf_pend_d = 64'(bin_in) > MAX_VAL;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shl;
        cnt_d = cnt_q - CW'(1);
        // last bit: publish result, saturating on overflow
        if (cnt_q == CW'(1)) begin
          bcd_d   = ovf_pend_q ? {DIGITS{BCD_NINE}}
                               : sr_shl[BIN_W +: OUT_W];
          ovf_d   = ovf_pend_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Inputs driven and outputs sampled on the falling edge.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(
    .BIN_W  (14),
    .DIGITS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic [13:0] v, output int bcnt,
                     output logic ok, output logic [15:0] res,
                     output logic rovf, output logic held,
                     output logic pulse1);
    logic [15:0] prev;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    prev   = bcd_out;
    @(negedge clk);
    start  = 1'b0;
    bcnt = 0; ok = 1'b0; held = 1'b1;
    res = '0; rovf = 1'b0; pulse1 = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done) begin
        ok = 1'b1; res = bcd_out; rovf = overflow;
      end else begin
        if (busy) bcnt++;
        if (bcd_out !== prev) held = 1'b0;
        @(negedge clk);
      end
    end
    if (ok) begin
      @(negedge clk);
      pulse1 = !done;
    end
  endtask

  initial begin
    int          bcnt;
    logic        ok, rovf, held, p1;
    logic [15:0] res, prev;
    logic [13:0] bv [4];
    logic [15:0] be [4];
    logic        bo [4];
    int          nd, tt [2];
    logic [15:0] rr [2];
    logic        nib_ok;
    logic [15:0] exp;

    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    run(14'd262, bcnt, ok, res, rovf, held, p1);
    chk("nom_ok", ok, 1);
    chk("nom_busy_cycles", bcnt, 14);
    chk("nom_bcd", res, 16'h0262);
    chk("nom_ovf", rovf, 0);
    chk("nom_done_1cyc", p1, 1);
    chk("nom_hold", held, 1);

    bv = '{14'd0, 14'd9999, 14'd10000, 14'd16383};
    be = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
    bo = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      run(bv[k], bcnt, ok, res, rovf, held, p1);
      chk($sformatf("bnd_ok_%0d", bv[k]), ok, 1);
      chk($sformatf("bnd_bcd_%0d", bv[k]), res, be[k]);
      chk($sformatf("bnd_ovf_%0d", bv[k]), rovf, bo[k]);
    end

    @(negedge clk);
    bin_in = 14'd262; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bcd", bcd_out, 16'h0000);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", nd, 0);
    run(14'd262, bcnt, ok, res, rovf, held, p1);
    chk("post_rst_bcd", res, 16'h0262);

    @(negedge clk);
    prev = bcd_out;
    bin_in = 14'd523; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = 14'd1047; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; held = 1'b1; res = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin nd++; res = bcd_out; end
      else if (busy && bcd_out !== prev) held = 1'b0;
      @(negedge clk);
    end
    chk("ign_done_count", nd, 1);
    chk("ign_bcd", res, 16'h0523);
    chk("ign_hold", held, 1);

    @(negedge clk);
    bin_in = 14'd440; start = 1'b1;
    @(negedge clk);
    bin_in = 14'd880;
    nd = 0; tt = '{0, 0}; rr = '{16'h0, 16'h0};
    for (int i = 1; i < 60 && nd < 2; i++) begin
      if (done) begin
        tt[nd] = i; rr[nd] = bcd_out; nd++;
        if (nd == 2) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_first", rr[0], 16'h0440);
    chk("b2b_second", rr[1], 16'h0880);
    chk("b2b_period", tt[1] - tt[0], 16);
    repeat (3) @(negedge clk);

    nib_ok = 1'b1;
    for (int v = 0; v < 100; v++) begin
      run(14'(v), bcnt, ok, res, rovf, held, p1);
      exp = {8'h00, 4'(v / 10), 4'(v % 10)};
      chk($sformatf("sweep_%0d", v), {15'h0, ok, res}, {15'h0, 1'b1, exp});
      for (int n = 0; n < 4; n++)
        if (res[n*4 +: 4] > 4'd9) nib_ok = 1'b0;
    end
    chk("sweep_nibbles_le9", nib_ok, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
